mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_div_step.sv | 26 ++
 rtl/mul_div_unit.sv | 155 +++++++++++++++
 tb/tb_mul_div_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the iteration count of the multi-cycle datapath.
package mdu_pkg;

   localparam int ITER_CNT = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX
   } state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
// The partial remainder shifts left taking the next dividend bit from the top
// of the quotient register; the new quotient bit enters at the bottom.
module mdu_div_step (
   input  logic [31:0] rem_i,
   input  logic [31:0] quo_i,
   input  logic [31:0] dvs_i,
   output logic [31:0] rem_o,
   output logic [31:0] quo_o
);

   logic [32:0] shifted;
   logic [31:0] diff;
   logic        ge;

   // Trial subtract; bit 32 of the shifted remainder means it already exceeds
   // any 32-bit divisor, and the low 32 bits of the difference are then exact.
   always_comb begin
      shifted = {rem_i, quo_i[31]};
      diff    = shifted[31:0] - dvs_i;
      ge      = shifted[32] | (shifted[31:0] >= dvs_i);
      rem_o   = ge ? diff : shifted[31:0];
      quo_o   = {quo_i[30:0], ge};
   end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS-style HI/LO multiply/divide unit.
// Iterative ops: IDLE -> CALC (32 steps) -> FIX (sign correction, HI/LO write).
// Operands are held as magnitudes; signs are restored in FIX.
// Define MDU_FAST_MUL_EN to complete MULT/MULTU in one cycle with a
// combinational multiplier; division is always iterative.
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   state_e      state_q;
   logic [5:0]  cnt_q;
   logic        is_div_q, neg_q, rneg_q, dz_q;
   logic [31:0] opnd_q;   // |multiplicand| or |divisor|
   logic [31:0] acc_q;    // product high half / partial remainder
   logic [31:0] wlo_q;    // multiplier shifting out / quotient shifting in
   logic [31:0] hi_q, lo_q;
   logic        busy_q, done_q;

   logic        is_mul, is_div, is_sgn, iter_op, sa, sb;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum_d;
   logic [31:0] div_rem_d, div_quo_d;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;

   assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
   assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
   assign sa     = is_sgn & a[31];
   assign sb     = is_sgn & b[31];
   assign mag_a  = sa ? -a : a;
   assign mag_b  = sb ? -b : b;

`ifdef MDU_FAST_MUL_EN
   logic [63:0] fast_prod;
   assign iter_op   = is_div;
   assign fast_prod = {{32{sa}}, a} * {{32{sb}}, b};
`else
   assign iter_op   = is_mul | is_div;
`endif

   // Shift-add step: add multiplicand when the current multiplier bit is set,
   // then shift the 64-bit {acc, wlo} pair right by one.
   assign mul_sum_d = {1'b0, acc_q} + (wlo_q[0] ? {1'b0, opnd_q} : 33'd0);

   mdu_div_step u_div_step (
      .rem_i (acc_q),
      .quo_i (wlo_q),
      .dvs_i (opnd_q),
      .rem_o (div_rem_d),
      .quo_o (div_quo_d)
   );

   // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient.
   assign prod_fix = neg_q ? -{acc_q, wlo_q} : {acc_q, wlo_q};
   assign quo_fix  = dz_q ? 32'hFFFF_FFFF : (neg_q ? -wlo_q : wlo_q);
   assign rem_fix  = rneg_q ? -acc_q : acc_q;

   // Control FSM plus datapath registers; reset beats flush beats start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         wlo_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (iter_op) begin
                     state_q  <= S_CALC;
                     busy_q   <= 1'b1;
                     cnt_q    <= '0;
                     is_div_q <= is_div;
                     neg_q    <= sa ^ sb;
                     rneg_q   <= sa;
                     dz_q     <= (b == 32'd0);
                     opnd_q   <= mag_b;
                     wlo_q    <= mag_a;
                     acc_q    <= '0;
                  end else if (op == OP_MTHI) begin
                     hi_q   <= a;
                     done_q <= 1'b1;
                  end else if (op == OP_MTLO) begin
                     lo_q   <= a;
                     done_q <= 1'b1;
`ifdef MDU_FAST_MUL_EN
                  end else if (is_mul) begin
                     {hi_q, lo_q} <= fast_prod;
                     done_q       <= 1'b1;
`endif
                  end
               end
            end
            S_CALC: begin
               if (is_div_q) begin
                  acc_q <= div_rem_d;
                  wlo_q <= div_quo_d;
               end else begin
                  acc_q <= mul_sum_d[32:1];
                  wlo_q <= {mul_sum_d[0], wlo_q[31:1]};
               end
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'(ITER_CNT - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed, table-driven bench for mul_div_unit, plus hand sequences for
// flush, start-while-busy and mid-operation reset.
module tb_mul_div_unit;
   import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int nchk = 0;
   int npass = 0;

   mul_div_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          elat;   // edges from accept to done; -1 = no done expected
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Called #1 after an edge. Issues one start and watches 41 samples.
   task automatic run_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         output int lat, output int nd, output int ovl);
      lat = -1; nd = 0; ovl = 0;
      op = o; a = aa; b = bb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (done) begin
            nd++;
            if (lat < 0) lat = k;
         end
         if (done && busy) ovl++;
      end
   endtask

   vec_t vecs[14];
   int   lat, nd, ovl;
   logic [31:0] save_hi, save_lo;

   initial begin
      vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
      vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
      vecs[2]  = '{OP_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, MUL_LAT};
      vecs[3]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MUL_LAT};
      vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT};
      vecs[5]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
      vecs[6]  = '{OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, DIV_LAT};
      vecs[7]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT};
      vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT};
      vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, DIV_LAT};
      vecs[10] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT};
      vecs[11] = '{OP_MTHI,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 0};
      vecs[12] = '{OP_MTLO,  32'hCAFE_BABE, 32'd9,         32'h1234_5678, 32'hCAFE_BABE, 0};
      vecs[13] = '{3'b111,   32'hDEAD_BEEF, 32'd1,         32'h1234_5678, 32'hCAFE_BABE, -1};

      rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_hi",   hi,   32'd0);
      chk("reset_lo",   lo,   32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nd, ovl);
         chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
         chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
         chk($sformatf("v%0d_ndone", i), nd, (vecs[i].elat >= 0) ? 32'd1 : 32'd0);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].elat);
         chk($sformatf("v%0d_done_busy_overlap", i), ovl, 32'd0);
      end

      // Flush at iteration 10 together with a new start: both abandoned.
      save_hi = hi; save_lo = lo;
      op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("flush_busy_after_accept", {31'd0, busy}, 32'd1);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'hDEAD_0001;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_done", {31'd0, done}, 32'd0);
      chk("flush_hi", hi, save_hi);
      chk("flush_lo", lo, save_lo);
      nd = 0; ovl = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) nd++;
         if (busy) ovl++;
      end
      chk("flush_no_late_done", nd, 32'd0);
      chk("flush_stays_idle", ovl, 32'd0);
      chk("flush_hi_hold", hi, save_hi);

      // Start while busy is ignored: only the first op completes.
      op = OP_DIVU; a = 32'd12; b = 32'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      op = OP_MTLO; a = 32'h1111_1111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) nd++;
         @(posedge clk); #1;
      end
      chk("busy_start_ndone", nd, 32'd1);
      chk("busy_start_lo", lo, 32'd3);
      chk("busy_start_hi", hi, 32'd0);

      // Reset mid-DIV clears everything the next cycle.
      op = OP_DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0; start = 1'b1; flush = 1'b1; op = OP_MTHI; a = 32'h5555_5555;
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b0; flush = 1'b0;
      chk("rst_mid_hi",   hi, 32'd0);
      chk("rst_mid_lo",   lo, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_done", {31'd0, done}, 32'd0);
      nd = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      chk("rst_mid_no_done", nd, 32'd0);

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nd, ovl);
      chk("rerun_multu_hi", hi, 32'hFFFF_FFFE);
      chk("rerun_multu_lo", lo, 32'h0000_0001);
      chk("rerun_multu_lat", lat, MUL_LAT);
      chk("rerun_multu_ndone", nd, 32'd1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
